sample_packer: RTL and testbench

SAMPLE_PACKER -- requirements
Module: sample_packer

---
 rtl/sample_packer.sv | 162 ++++++++++++++++
 tb/tb_sample_packer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_packer.sv
// sample_packer: assembles four phase-strobed byte lanes of a probe channel
// into 32-bit words and queues them in a 2-entry output FIFO.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | run disabled; FIFO still drains, counters/flags held
//   S_CAPTURE | lanes captured in order 1->2->4->8, words pushed to FIFO
//   S_DONE    | DEPTH words pushed; strobes ignored, FIFO drains
module sample_packer #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        CLKin,
  input  logic        RSTn,
  input  logic        start,
  input  logic [3:0]  phase,
  input  logic [7:0]  din,
  output logic [31:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [15:0] word_count,
  output logic        done,
  output logic        overflow,
  output logic        seq_err
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  localparam logic [15:0] DEPTH_W = DEPTH[15:0];

  state_t      state, state_n;
  logic [1:0]  lane, lane_eff, lane_n;
  logic [31:0] asm_q, asm_n;
  logic [31:0] push_word;
  logic        push_req, push_ok, pop, full, seq_set;
  logic        active, first, one_hot, last_word;
  logic [15:0] count_base, count_inc, count_n;
  logic        ovf_base, serr_base, overflow_n, seq_err_n;

  logic [31:0] mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  fifo_cnt;

  // The IDLE->CAPTURE cycle sees cleared run state so a strobe in that
  // same cycle is handled as the first strobe of a fresh run.
  assign first      = (state == S_IDLE) && start;
  assign active     = start && (state != S_DONE);
  assign lane_eff   = first ? 2'd0 : lane;
  assign count_base = first ? 16'd0 : word_count;
  assign ovf_base   = first ? 1'b0 : overflow;
  assign serr_base  = first ? 1'b0 : seq_err;
  assign one_hot    = (phase != 4'b0) && ((phase & (phase - 4'd1)) == 4'b0);

  assign full       = (fifo_cnt == 2'd2);
  assign pop        = word_valid && word_ready;
  assign push_ok    = push_req && (!full || pop);
  assign count_inc  = count_base + 16'd1;
  assign last_word  = (count_inc == DEPTH_W);

  // Lane sequencing and word assembly
  always_comb begin
    lane_n    = lane;
    asm_n     = asm_q;
    push_req  = 1'b0;
    push_word = {din, asm_q[23:0]};
    seq_set   = 1'b0;
    if (!active) begin
      if (!start) begin
        lane_n = 2'd0;
        asm_n  = 32'b0;
      end
    end else begin
      lane_n = lane_eff;
      if (phase == 4'b0) begin
        lane_n = lane_eff;
      end else if (phase == (4'b0001 << lane_eff)) begin
        asm_n[{lane_eff, 3'b000} +: 8] = din;
        lane_n = lane_eff + 2'd1;
        if (lane_eff == 2'd3) push_req = 1'b1;
      end else if (one_hot) begin
        seq_set = 1'b1;
        if (phase == 4'b0001) begin
          asm_n  = {24'b0, din};
          lane_n = 2'd1;
        end else begin
          asm_n  = 32'b0;
          lane_n = 2'd0;
        end
      end else begin
        seq_set = 1'b1;
        asm_n   = 32'b0;
        lane_n  = 2'd0;
      end
    end
  end

  // Run counters and sticky flags
  always_comb begin
    count_n    = count_base;
    overflow_n = ovf_base | (push_req & !push_ok);
    seq_err_n  = serr_base | seq_set;
    if (push_ok && (count_base != DEPTH_W)) count_n = count_inc;
  end

  // Next-state logic; start low always returns to idle
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (start) state_n = S_CAPTURE;
      S_CAPTURE: if (push_ok && last_word) state_n = S_DONE;
      S_DONE:    state_n = S_DONE;
      default:   state_n = S_IDLE;
    endcase
    if (first && push_ok && last_word) state_n = S_DONE;
    if (!start) state_n = S_IDLE;
  end

  // State, lane pointer, assembly register and run status
  always_ff @(posedge CLKin or negedge RSTn) begin
    if (!RSTn) begin
      state      <= S_IDLE;
      lane       <= 2'd0;
      asm_q      <= 32'b0;
      word_count <= 16'd0;
      overflow   <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      state      <= state_n;
      lane       <= lane_n;
      asm_q      <= asm_n;
      word_count <= count_n;
      overflow   <= overflow_n;
      seq_err    <= seq_err_n;
    end
  end

  // Two-entry output FIFO; a push into a full FIFO is accepted when it pops
  always_ff @(posedge CLKin or negedge RSTn) begin
    if (!RSTn) begin
      mem[0]   <= 32'b0;
      mem[1]   <= 32'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign word_data  = mem[rd_ptr];
  assign word_valid = (fifo_cnt != 2'd0);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_sample_packer.sv
// Directed bench for sample_packer, built with DEPTH=4.
module tb_sample_packer;

  logic        CLKin = 1'b0;
  logic        RSTn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  phase = 4'b0;
  logic [7:0]  din = 8'h00;
  logic        word_ready = 1'b0;
  logic [31:0] word_data;
  logic        word_valid;
  logic [15:0] word_count;
  logic        done;
  logic        overflow;
  logic        seq_err;

  int n_checks = 0;
  int n_fail   = 0;

  sample_packer #(.DEPTH(4)) dut (
    .CLKin(CLKin), .RSTn(RSTn), .start(start), .phase(phase), .din(din),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .word_count(word_count), .done(done), .overflow(overflow), .seq_err(seq_err)
  );

  always #5 CLKin = ~CLKin;

  task automatic tick();
    @(posedge CLKin);
    #1;
  endtask

  task automatic strobe(input logic [3:0] p, input logic [7:0] d);
    phase = p;
    din   = d;
    tick();
    phase = 4'b0;
  endtask

  task automatic put_word(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    strobe(4'b0001, b0);
    strobe(4'b0010, b1);
    strobe(4'b0100, b2);
    strobe(4'b1000, b3);
  endtask

  task automatic restart();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({word_valid, word_data, word_count, done, overflow, seq_err} !== 52'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b d=%h c=%0d dn=%b o=%b s=%b want all zero",
               word_valid, word_data, word_count, done, overflow, seq_err);
    end
    RSTn = 1'b1;
    tick();
    n_checks++;
    if (word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_valid got %b want 0", word_valid);
    end
  endtask

  task automatic test_basic();
    word_ready = 1'b1;
    start = 1'b0;
    tick();
    start = 1'b1;
    put_word(8'h11, 8'h22, 8'h33, 8'h44);
    n_checks++;
    if (word_valid !== 1'b1 || word_data !== 32'h44332211) begin
      n_fail++;
      $display("FAIL basic_word got v=%b d=%h want v=1 d=44332211", word_valid, word_data);
    end
    n_checks++;
    if (word_count !== 16'd1) begin
      n_fail++;
      $display("FAIL basic_count got %0d want 1", word_count);
    end
    tick();
    n_checks++;
    if (word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drained got %b want 0", word_valid);
    end
  endtask

  task automatic test_depth();
    logic [7:0] k8;
    word_ready = 1'b1;
    restart();
    for (int k = 1; k <= 4; k++) begin
      k8 = 8'(k);
      put_word(k8, 8'hB0, 8'hC0, 8'hD0);
      n_checks++;
      if (word_count !== 16'(k) || word_data !== {8'hD0, 8'hC0, 8'hB0, k8}) begin
        n_fail++;
        $display("FAIL depth_word%0d got c=%0d d=%h want c=%0d d=%h",
                 k, word_count, word_data, k, {8'hD0, 8'hC0, 8'hB0, k8});
      end
      n_checks++;
      if (done !== (k == 4)) begin
        n_fail++;
        $display("FAIL depth_done%0d got %b want %b", k, done, (k == 4));
      end
    end
    tick();
    put_word(8'h55, 8'h66, 8'h77, 8'h88);
    n_checks++;
    if (word_count !== 16'd4 || done !== 1'b1 || word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL depth_halt got c=%0d dn=%b v=%b want c=4 dn=1 v=0",
               word_count, done, word_valid);
    end
  endtask

  task automatic test_overflow();
    word_ready = 1'b0;
    restart();
    n_checks++;
    if (done !== 1'b0 || word_count !== 16'd0) begin
      n_fail++;
      $display("FAIL ovf_restart got dn=%b c=%0d want dn=0 c=0", done, word_count);
    end
    put_word(8'h01, 8'h02, 8'h03, 8'h04);
    put_word(8'h11, 8'h12, 8'h13, 8'h14);
    n_checks++;
    if (overflow !== 1'b0 || word_count !== 16'd2) begin
      n_fail++;
      $display("FAIL ovf_two got o=%b c=%0d want o=0 c=2", overflow, word_count);
    end
    put_word(8'h21, 8'h22, 8'h23, 8'h24);
    n_checks++;
    if (overflow !== 1'b1 || word_count !== 16'd2) begin
      n_fail++;
      $display("FAIL ovf_drop got o=%b c=%0d want o=1 c=2", overflow, word_count);
    end
    n_checks++;
    if (word_valid !== 1'b1 || word_data !== 32'h04030201) begin
      n_fail++;
      $display("FAIL ovf_head got v=%b d=%h want v=1 d=04030201", word_valid, word_data);
    end
    word_ready = 1'b1;
    tick();
    n_checks++;
    if (word_valid !== 1'b1 || word_data !== 32'h14131211) begin
      n_fail++;
      $display("FAIL ovf_second got v=%b d=%h want v=1 d=14131211", word_valid, word_data);
    end
    tick();
    n_checks++;
    if (word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_empty got %b want 0", word_valid);
    end
  endtask

  task automatic test_seq_err();
    word_ready = 1'b1;
    restart();
    strobe(4'b0001, 8'hE1);
    strobe(4'b0010, 8'hE2);
    strobe(4'b1000, 8'hE4);
    n_checks++;
    if (seq_err !== 1'b1 || word_valid !== 1'b0 || word_count !== 16'd0) begin
      n_fail++;
      $display("FAIL seq_skip got s=%b v=%b c=%0d want s=1 v=0 c=0",
               seq_err, word_valid, word_count);
    end
    put_word(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    n_checks++;
    if (word_valid !== 1'b1 || word_data !== 32'hA4A3A2A1 || word_count !== 16'd1) begin
      n_fail++;
      $display("FAIL seq_recover got v=%b d=%h c=%0d want v=1 d=A4A3A2A1 c=1",
               word_valid, word_data, word_count);
    end
    restart();
    strobe(4'b0001, 8'h01);
    strobe(4'b0011, 8'h02);
    n_checks++;
    if (seq_err !== 1'b1) begin
      n_fail++;
      $display("FAIL seq_multihot got %b want 1", seq_err);
    end
    strobe(4'b0010, 8'h03);
    n_checks++;
    if (word_count !== 16'd0 || word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_lane_reset got c=%0d v=%b want c=0 v=0", word_count, word_valid);
    end
    strobe(4'b0100, 8'h5A);
    strobe(4'b0001, 8'h51);
    strobe(4'b0010, 8'h52);
    strobe(4'b0100, 8'h53);
    strobe(4'b1000, 8'h54);
    n_checks++;
    if (word_valid !== 1'b1 || word_data !== 32'h54535251) begin
      n_fail++;
      $display("FAIL seq_wait_lane0 got v=%b d=%h want v=1 d=54535251", word_valid, word_data);
    end
    tick();
  endtask

  task automatic test_start_strobe();
    word_ready = 1'b1;
    start = 1'b0;
    tick();
    start = 1'b1;
    put_word(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    n_checks++;
    if (word_valid !== 1'b1 || word_data !== 32'hC4C3C2C1 || seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL start_strobe got v=%b d=%h s=%b want v=1 d=C4C3C2C1 s=0",
               word_valid, word_data, seq_err);
    end
    tick();
  endtask

  task automatic test_start_drop();
    word_ready = 1'b0;
    restart();
    strobe(4'b0010, 8'h99);
    put_word(8'hD1, 8'hD2, 8'hD3, 8'hD4);
    strobe(4'b0001, 8'hE1);
    strobe(4'b0010, 8'hE2);
    start = 1'b0;
    tick();
    strobe(4'b0100, 8'hE3);
    strobe(4'b1000, 8'hE4);
    n_checks++;
    if (word_valid !== 1'b1 || word_data !== 32'hD4D3D2D1 || word_count !== 16'd1) begin
      n_fail++;
      $display("FAIL drop_hold got v=%b d=%h c=%0d want v=1 d=D4D3D2D1 c=1",
               word_valid, word_data, word_count);
    end
    n_checks++;
    if (seq_err !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_seq_kept got %b want 1", seq_err);
    end
    word_ready = 1'b1;
    tick();
    n_checks++;
    if (word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_drained got %b want 0", word_valid);
    end
    start = 1'b1;
    tick();
    n_checks++;
    if (word_count !== 16'd0 || seq_err !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_restart got c=%0d s=%b o=%b want 0 0 0", word_count, seq_err, overflow);
    end
    put_word(8'hF1, 8'hF2, 8'hF3, 8'hF4);
    n_checks++;
    if (word_data !== 32'hF4F3F2F1 || word_count !== 16'd1) begin
      n_fail++;
      $display("FAIL drop_fresh got d=%h c=%0d want F4F3F2F1 1", word_data, word_count);
    end
    tick();
  endtask

  task automatic test_async_reset();
    word_ready = 1'b0;
    restart();
    strobe(4'b0010, 8'h00);
    put_word(8'h31, 8'h32, 8'h33, 8'h34);
    strobe(4'b0001, 8'h41);
    #2;
    RSTn = 1'b0;
    #1;
    n_checks++;
    if ({word_valid, word_data, word_count, done, overflow, seq_err} !== 52'b0) begin
      n_fail++;
      $display("FAIL async_reset got v=%b d=%h c=%0d dn=%b o=%b s=%b want all zero",
               word_valid, word_data, word_count, done, overflow, seq_err);
    end
    start = 1'b0;
    tick();
    RSTn = 1'b1;
    tick();
    tick();
    n_checks++;
    if (word_valid !== 1'b0 || word_count !== 16'd0) begin
      n_fail++;
      $display("FAIL async_after got v=%b c=%0d want v=0 c=0", word_valid, word_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_depth();
    test_overflow();
    test_seq_err();
    test_start_strobe();
    test_start_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
